// File: rtl/alu_exu.sv
// alu_exu: integer ALU execution stage. One issued instruction per cycle is
// evaluated by the combinational alu and its result is held in a 2-entry
// in-order buffer. The head entry is offered to the writeback arbiter.
// Entries younger than a pipeline flush are dropped.
//
// alu_type one-hot bit assignment:
//   [0] add  [1] slt (sltu when is_unsigned)  [2] xor  [3] or  [4] and
//   [5] sll  [6] srl  [7] sra  [8] sub  [9] lui  [10] auipc
// lui expects imm already shifted into place; auipc returns pc + imm.
// is_word selects the 32-bit form: 5-bit shift amount, result sign-extended.

module alu (
   input  logic        valid,
   input  logic [63:0] src1,
   input  logic [63:0] src2,
   input  logic [63:0] imm,
   input  logic [63:0] pc,
   input  logic [10:0] alu_type,
   input  logic        is_word,
   input  logic        is_unsigned,
   input  logic        is_imm,
   output logic [63:0] result
);

   logic [63:0] op2;
   logic [5:0]  shamt;
   logic [63:0] sum;
   logic [63:0] diff;
   logic        lt;
   logic [63:0] sll_r;
   logic [63:0] srl_r;
   logic [63:0] sra_r;
   logic [63:0] sra_src;
   logic [63:0] raw;

   // Compute every candidate result in parallel, then pick by the one-hot type
   always_comb begin
      op2     = is_imm ? imm : src2;
      shamt   = is_word ? {1'b0, op2[4:0]} : op2[5:0];
      sum     = src1 + op2;
      diff    = src1 - op2;
      lt      = is_unsigned ? (src1 < op2) : ($signed(src1) < $signed(op2));
      sll_r   = src1 << shamt;
      srl_r   = (is_word ? {32'b0, src1[31:0]} : src1) >> shamt;
      sra_src = is_word ? {{32{src1[31]}}, src1[31:0]} : src1;
      sra_r   = $signed(sra_src) >>> shamt;
      raw     = ({64{alu_type[0]}}  & sum)
              | ({64{alu_type[1]}}  & {63'b0, lt})
              | ({64{alu_type[2]}}  & (src1 ^ op2))
              | ({64{alu_type[3]}}  & (src1 | op2))
              | ({64{alu_type[4]}}  & (src1 & op2))
              | ({64{alu_type[5]}}  & sll_r)
              | ({64{alu_type[6]}}  & srl_r)
              | ({64{alu_type[7]}}  & sra_r)
              | ({64{alu_type[8]}}  & diff)
              | ({64{alu_type[9]}}  & imm)
              | ({64{alu_type[10]}} & (pc + imm));
      if (is_word) begin
         raw = {{32{raw[31]}}, raw[31:0]};
      end
      result = valid ? raw : 64'b0;
   end

endmodule

module alu_exu #(
   parameter int ROBID_W = 7,
   parameter int PREG_W  = 6
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [63:0]        src1,
   input  logic [63:0]        src2,
   input  logic [63:0]        imm,
   input  logic [63:0]        pc,
   input  logic [10:0]        alu_type,
   input  logic               is_word,
   input  logic               is_unsigned,
   input  logic               is_imm,
   input  logic [PREG_W-1:0]  instr_prd,
   input  logic [ROBID_W-1:0] instr_robid,
   input  logic               instr_need_wb,
   input  logic               flush_valid,
   input  logic [ROBID_W-1:0] flush_robid,
   output logic               wb_valid,
   input  logic               wb_ready,
   output logic [63:0]        wb_result,
   output logic [PREG_W-1:0]  wb_prd,
   output logic [ROBID_W-1:0] wb_robid,
   output logic               wb_need_wb
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are
   // both high. valid never depends on ready; ready is derived from
   // registered occupancy (and flush/reset) only.

   typedef struct packed {
      logic [63:0]        result;
      logic [PREG_W-1:0]  prd;
      logic [ROBID_W-1:0] robid;
      logic               need_wb;
   } entry_t;

   entry_t      e0, e1;        // e0 is the head (oldest)
   entry_t      n_e0, n_e1;
   entry_t      new_e;
   logic [1:0]  count, n_count;
   logic [63:0] alu_result;
   logic        enq, deq;
   logic        kill0, kill1, keep0, keep1;

   // A is younger than F, accounting for the ROB wrap bit
   function automatic logic younger(input logic [ROBID_W-1:0] a,
                                    input logic [ROBID_W-1:0] f);
      logic same_wrap;
      same_wrap = (a[ROBID_W-1] == f[ROBID_W-1]);
      return (same_wrap  && (a[ROBID_W-2:0] > f[ROBID_W-2:0])) ||
             (!same_wrap && (a[ROBID_W-2:0] < f[ROBID_W-2:0]));
   endfunction

   alu u_alu (
      .valid       (instr_valid),
      .src1        (src1),
      .src2        (src2),
      .imm         (imm),
      .pc          (pc),
      .alu_type    (alu_type),
      .is_word     (is_word),
      .is_unsigned (is_unsigned),
      .is_imm      (is_imm),
      .result      (alu_result)
   );

   assign instr_ready = ~reset & ~flush_valid & ~count[1];
   assign kill0       = flush_valid & younger(e0.robid, flush_robid);
   assign kill1       = flush_valid & younger(e1.robid, flush_robid);
   assign wb_valid    = (count != 2'd0) & ~kill0;
   assign enq         = instr_valid & instr_ready;
   assign deq         = wb_valid & wb_ready;

   assign wb_result   = e0.result;
   assign wb_prd      = e0.prd;
   assign wb_robid    = e0.robid;
   assign wb_need_wb  = e0.need_wb;

   // Compact survivors of dequeue/flush toward the head, then append the new entry
   always_comb begin
      new_e.result  = alu_result;
      new_e.prd     = instr_prd;
      new_e.robid   = instr_robid;
      new_e.need_wb = instr_need_wb;
      keep0   = (count != 2'd0) & ~kill0 & ~deq;
      keep1   = (count == 2'd2) & ~kill1;
      n_e0    = e0;
      n_e1    = e1;
      n_count = 2'd0;
      if (keep0) begin
         n_count = keep1 ? 2'd2 : 2'd1;
      end else if (keep1) begin
         n_e0    = e1;
         n_count = 2'd1;
      end
      // enq implies count < 2, so at most one survivor is present here
      if (enq) begin
         if (n_count == 2'd0) begin
            n_e0 = new_e;
         end else begin
            n_e1 = new_e;
         end
         n_count = n_count + 2'd1;
      end
   end

   // Buffer state; reset empties it and zeroes the presented head fields
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= 2'd0;
         e0    <= '0;
         e1    <= '0;
      end else begin
         count <= n_count;
         e0    <= n_e0;
         e1    <= n_e1;
      end
   end

endmodule

// File: tb/tb_alu_exu.sv
// tb_alu_exu: directed scoreboard bench for the integer ALU execution stage.
module tb_alu_exu;

   localparam logic [10:0] OP_ADD   = 11'b000_0000_0001;
   localparam logic [10:0] OP_SLT   = 11'b000_0000_0010;
   localparam logic [10:0] OP_XOR   = 11'b000_0000_0100;
   localparam logic [10:0] OP_OR    = 11'b000_0000_1000;
   localparam logic [10:0] OP_AND   = 11'b000_0001_0000;
   localparam logic [10:0] OP_SLL   = 11'b000_0010_0000;
   localparam logic [10:0] OP_SRL   = 11'b000_0100_0000;
   localparam logic [10:0] OP_SRA   = 11'b000_1000_0000;
   localparam logic [10:0] OP_SUB   = 11'b001_0000_0000;
   localparam logic [10:0] OP_LUI   = 11'b010_0000_0000;
   localparam logic [10:0] OP_AUIPC = 11'b100_0000_0000;
   localparam int          W        = 78;  // {result, prd, robid, need_wb}

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [63:0] src1 = '0, src2 = '0, imm = '0, pc = '0;
   logic [10:0] alu_type = '0;
   logic        is_word = 1'b0, is_unsigned = 1'b0, is_imm = 1'b0;
   logic [5:0]  instr_prd = '0;
   logic [6:0]  instr_robid = '0;
   logic        instr_need_wb = 1'b0;
   logic        flush_valid = 1'b0;
   logic [6:0]  flush_robid = '0;
   logic        wb_valid;
   logic        wb_ready = 1'b0;
   logic [63:0] wb_result;
   logic [5:0]  wb_prd;
   logic [6:0]  wb_robid;
   logic        wb_need_wb;

   logic [W-1:0] exp_q[$];
   int           chk_cnt = 0;
   int           pass_cnt = 0;

   alu_exu #(.ROBID_W(7), .PREG_W(6)) dut (
      .clock(clock), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .src1(src1), .src2(src2), .imm(imm), .pc(pc),
      .alu_type(alu_type), .is_word(is_word), .is_unsigned(is_unsigned), .is_imm(is_imm),
      .instr_prd(instr_prd), .instr_robid(instr_robid), .instr_need_wb(instr_need_wb),
      .flush_valid(flush_valid), .flush_robid(flush_robid),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_result(wb_result), .wb_prd(wb_prd), .wb_robid(wb_robid), .wb_need_wb(wb_need_wb)
   );

   // Clock
   always #5 clock = ~clock;

   function automatic bit younger(input logic [6:0] a, input logic [6:0] f);
      if (a[6] == f[6]) return a[5:0] > f[5:0];
      return a[5:0] < f[5:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic set_instr(input logic [10:0] t, input logic [63:0] s1, input logic [63:0] s2,
                            input logic [63:0] im, input logic [63:0] p, input logic w,
                            input logic u, input logic ii, input logic [5:0] prd,
                            input logic [6:0] rid);
      instr_valid = 1'b1;
      alu_type = t; src1 = s1; src2 = s2; imm = im; pc = p;
      is_word = w; is_unsigned = u; is_imm = ii;
      instr_prd = prd; instr_robid = rid; instr_need_wb = (prd != 6'd0);
   endtask

   task automatic push_exp(input logic [63:0] res, input logic [5:0] prd, input logic [6:0] rid);
      exp_q.push_back({res, prd, rid, (prd != 6'd0)});
   endtask

   // Driver: present one instruction, wait (bounded) for acceptance; ends at posedge+1
   task automatic issue(input logic [10:0] t, input logic [63:0] s1, input logic [63:0] s2,
                        input logic [63:0] im, input logic [63:0] p, input logic w,
                        input logic u, input logic ii, input logic [5:0] prd,
                        input logic [6:0] rid, input logic [63:0] res);
      int n = 0;
      set_instr(t, s1, s2, im, p, w, u, ii, prd, rid);
      @(negedge clock);
      while (!instr_ready && n < 20) begin
         n++;
         @(posedge clock);
         @(negedge clock);
      end
      if (!instr_ready) begin
         chk_cnt++;
         $display("FAIL issue_timeout: robid %0d never accepted", rid);
      end else begin
         push_exp(res, prd, rid);
      end
      @(posedge clock);
      #1;
      instr_valid = 1'b0;
   endtask

   // Driver: assert a flush and drop younger expectations from the scoreboard
   task automatic do_flush(input logic [6:0] f);
      logic [W-1:0] keep_q[$];
      flush_valid = 1'b1;
      flush_robid = f;
      foreach (exp_q[i]) if (!younger(exp_q[i][7:1], f)) keep_q.push_back(exp_q[i]);
      exp_q = keep_q;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   // Monitor: compare each written-back head against the scoreboard
   always @(negedge clock) begin
      logic [W-1:0] e;
      if (!reset && wb_valid && wb_ready) begin
         if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL wb_unexpected: robid %0d presented, nothing expected", wb_robid);
         end else begin
            e = exp_q.pop_front();
            check("wb_result", wb_result, e[77:14]);
            check("wb_prd", {58'b0, wb_prd}, {58'b0, e[13:8]});
            check("wb_robid", {57'b0, wb_robid}, {57'b0, e[7:1]});
            check("wb_need_wb", {63'b0, wb_need_wb}, {63'b0, e[0]});
         end
      end
   end

   initial begin
      int n;
      // Reset values while reset is asserted
      @(negedge clock);
      @(negedge clock);
      check("rst_instr_ready", {63'b0, instr_ready}, 64'd0);
      check("rst_wb_valid", {63'b0, wb_valid}, 64'd0);
      check("rst_wb_result", wb_result, 64'd0);
      check("rst_wb_fields", {50'b0, wb_prd, wb_robid, wb_need_wb}, 64'd0);
      next_cycle();
      reset = 1'b0;
      @(negedge clock);
      check("ready_after_rst", {63'b0, instr_ready}, 64'd1);
      next_cycle();

      // Basic add with one-cycle latency
      wb_ready = 1'b1;
      issue(OP_ADD, 64'd5, 64'd7, 64'd0, 64'd0, 0, 0, 0, 6'd9, 7'd3, 64'd12);
      @(negedge clock);
      check("add_latency_valid", {63'b0, wb_valid}, 64'd1);
      check("add_result", wb_result, 64'd12);
      next_cycle();

      // Back-to-back issue at full throughput
      set_instr(OP_ADD, 64'h7FFF_FFFF, 64'd1, 64'd0, 64'd0, 1, 0, 0, 6'd10, 7'd6);
      push_exp(64'hFFFF_FFFF_8000_0000, 6'd10, 7'd6);
      next_cycle();
      set_instr(OP_SRA, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'd0, 0, 0, 0, 6'd11, 7'd7);
      push_exp(64'hF800_0000_0000_0000, 6'd11, 7'd7);
      @(negedge clock);
      check("b2b_ready", {63'b0, instr_ready}, 64'd1);
      check("b2b_first", wb_result, 64'hFFFF_FFFF_8000_0000);
      next_cycle();
      instr_valid = 1'b0;
      @(negedge clock);
      check("b2b_ready2", {63'b0, instr_ready}, 64'd1);
      check("b2b_second", wb_result, 64'hF800_0000_0000_0000);
      next_cycle();

      // Backpressure fills the buffer, then drains in order
      wb_ready = 1'b0;
      issue(OP_XOR, 64'hFF, 64'h0F, 64'd0, 64'd0, 0, 0, 0, 6'd4, 7'd4, 64'hF0);
      issue(OP_OR, 64'hF0, 64'h0F, 64'd0, 64'd0, 0, 0, 0, 6'd5, 7'd5, 64'hFF);
      @(negedge clock);
      check("full_ready_low", {63'b0, instr_ready}, 64'd0);
      check("full_head", {57'b0, wb_robid}, 64'd4);
      next_cycle();
      @(negedge clock);
      check("stall_head_stable", {57'b0, wb_robid}, 64'd4);
      check("stall_result_stable", wb_result, 64'hF0);
      next_cycle();
      wb_ready = 1'b1;
      @(negedge clock);
      check("deq_cycle_ready_low", {63'b0, instr_ready}, 64'd0);
      next_cycle();
      @(negedge clock);
      check("after_deq_ready", {63'b0, instr_ready}, 64'd1);
      check("second_head", {57'b0, wb_robid}, 64'd5);
      next_cycle();

      // Flush keeps the older entry only
      wb_ready = 1'b0;
      issue(OP_AND, 64'hF0F0, 64'hFF00, 64'd0, 64'd0, 0, 0, 0, 6'd12, 7'd10, 64'hF000);
      issue(OP_SUB, 64'd3, 64'd5, 64'd0, 64'd0, 0, 0, 0, 6'd13, 7'd12, 64'hFFFF_FFFF_FFFF_FFFE);
      do_flush(7'd11);
      @(negedge clock);
      check("flush11_head_valid", {63'b0, wb_valid}, 64'd1);
      check("flush11_head_robid", {57'b0, wb_robid}, 64'd10);
      check("flush_ready_low", {63'b0, instr_ready}, 64'd0);
      next_cycle();
      flush_valid = 1'b0;
      @(negedge clock);
      check("flush11_survivor", {57'b0, wb_robid}, 64'd10);
      check("flush11_ready", {63'b0, instr_ready}, 64'd1);
      next_cycle();
      wb_ready = 1'b1;
      next_cycle();
      @(negedge clock);
      check("flush11_drained", {63'b0, wb_valid}, 64'd0);
      next_cycle();

      // Flush kills both entries; no handshake on the killed head
      wb_ready = 1'b0;
      issue(OP_AND, 64'hF0F0, 64'hFF00, 64'd0, 64'd0, 0, 0, 0, 6'd12, 7'd10, 64'hF000);
      issue(OP_SUB, 64'd3, 64'd5, 64'd0, 64'd0, 0, 0, 0, 6'd13, 7'd12, 64'hFFFF_FFFF_FFFF_FFFE);
      wb_ready = 1'b1;
      do_flush(7'd9);
      @(negedge clock);
      check("flush9_valid_now", {63'b0, wb_valid}, 64'd0);
      next_cycle();
      flush_valid = 1'b0;
      @(negedge clock);
      check("flush9_valid_after", {63'b0, wb_valid}, 64'd0);
      next_cycle();

      // Wrap-bit age comparison
      wb_ready = 1'b0;
      issue(OP_ADD, 64'd1, 64'd1, 64'd0, 64'd0, 0, 0, 0, 6'd14, 7'h42, 64'd2);
      do_flush(7'd60);
      @(negedge clock);
      check("wrap_younger_killed", {63'b0, wb_valid}, 64'd0);
      next_cycle();
      flush_valid = 1'b0;
      @(negedge clock);
      check("wrap_still_empty", {63'b0, wb_valid}, 64'd0);
      next_cycle();
      issue(OP_ADD, 64'd2, 64'd2, 64'd0, 64'd0, 0, 0, 0, 6'd15, 7'h42, 64'd4);
      do_flush(7'h42);
      @(negedge clock);
      check("equal_id_kept", {63'b0, wb_valid}, 64'd1);
      next_cycle();
      flush_valid = 1'b0;
      @(negedge clock);
      check("equal_id_robid", {57'b0, wb_robid}, 64'h42);
      next_cycle();
      wb_ready = 1'b1;
      next_cycle();

      // Reset while full clears outputs immediately
      wb_ready = 1'b0;
      issue(OP_ADD, 64'd8, 64'd8, 64'd0, 64'd0, 0, 0, 0, 6'd16, 7'd40, 64'd16);
      issue(OP_ADD, 64'd9, 64'd9, 64'd0, 64'd0, 0, 0, 0, 6'd17, 7'd41, 64'd18);
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_wb_valid", {63'b0, wb_valid}, 64'd0);
      check("midrst_wb_result", wb_result, 64'd0);
      check("midrst_wb_fields", {50'b0, wb_prd, wb_robid, wb_need_wb}, 64'd0);
      check("midrst_ready", {63'b0, instr_ready}, 64'd0);
      next_cycle();
      reset = 1'b0;
      wb_ready = 1'b1;
      issue(OP_SUB, 64'd20, 64'd7, 64'd0, 64'd0, 0, 0, 0, 6'd18, 7'd20, 64'd13);
      @(negedge clock);
      check("postrst_valid", {63'b0, wb_valid}, 64'd1);
      check("postrst_robid", {57'b0, wb_robid}, 64'd20);
      next_cycle();
      @(negedge clock);
      check("postrst_alone", {63'b0, wb_valid}, 64'd0);
      next_cycle();

      // Directed operation vectors
      issue(OP_ADD, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 0, 1, 6'd1, 7'd30, 64'd99);
      issue(OP_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 0, 0, 0, 6'd2, 7'd31, 64'd1);
      issue(OP_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 0, 1, 0, 6'd3, 7'd32, 64'd0);
      issue(OP_SLL, 64'd1, 64'd0, 64'd63, 64'd0, 0, 0, 1, 6'd4, 7'd33, 64'h8000_0000_0000_0000);
      issue(OP_SLL, 64'd1, 64'd31, 64'd0, 64'd0, 1, 0, 0, 6'd5, 7'd34, 64'hFFFF_FFFF_8000_0000);
      issue(OP_SRL, 64'h8000_0000, 64'd4, 64'd0, 64'd0, 1, 0, 0, 6'd6, 7'd35, 64'h0800_0000);
      issue(OP_SRA, 64'h8000_0000, 64'd4, 64'd0, 64'd0, 1, 0, 0, 6'd7, 7'd36, 64'hFFFF_FFFF_F800_0000);
      issue(OP_LUI, 64'd0, 64'd0, 64'h1234_5000, 64'd0, 0, 0, 1, 6'd8, 7'd37, 64'h1234_5000);
      issue(OP_AUIPC, 64'd0, 64'd0, 64'h2000, 64'h1000, 0, 0, 1, 6'd9, 7'd38, 64'h3000);
      issue(OP_ADD, 64'd1, 64'd2, 64'd0, 64'd0, 0, 0, 0, 6'd0, 7'd39, 64'd3);

      // Drain and confirm nothing expected was left unseen
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         n++;
         next_cycle();
      end
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/alu_exu.md
# alu_exu

Integer ALU execution stage: accepts one issued integer instruction per cycle from the integer issue queue and evaluates it through the combinational `alu` function unit. It holds results in a 2-entry in-order result buffer and presents them to the writeback arbiter with a valid/ready handshake. Buffered entries younger than a pipeline flush (branch mispredict or exception redirect) are dropped.

## Interface
- `ROBID_W`, default 7: ROB index width including MSB wrap bit.
- `PREG_W`, default 6: physical register index width.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `instr_valid` in 1: issue queue presents an instruction.
- `instr_ready` out 1: stage accepts; transfer when valid & ready.
- `src1`, `src2`, `imm` in 64 each: operands and immediate.
- `pc` in 64: instruction PC.
- `alu_type` in 11: one-hot op {add, slt, sltu-with-is_unsigned, xor, or, and, sll, srl, sra, sub, lui, auipc}.
- `is_word`, `is_unsigned`, `is_imm` in 1 each: passed unchanged to `alu`.
- `instr_prd` in PREG_W: destination physical register.
- `instr_robid` in ROBID_W: ROB id.
- `instr_need_wb` in 1: instruction writes a register (rd ≠ x0).
- `flush_valid` in 1: redirect this cycle.
- `flush_robid` in ROBID_W: ROB id of the redirecting instruction.
- `wb_valid` out 1: head result valid.
- `wb_ready` in 1: arbiter consumes head.
- `wb_result` out 64, `wb_prd` out PREG_W, `wb_robid` out ROBID_W, `wb_need_wb` out 1: head entry fields.

## Operation
- `alu` instantiated with `valid` = `instr_valid`; its result is captured together with prd, robid and need_wb into the buffer tail on the cycle of the issue handshake.
- Buffer: 2 entries, in-order, head = entry 0, occupancy count 0..2.
- `instr_ready` = `~flush_valid & (count < 2)`, computed from registered count only. There is no same-cycle dequeue bypass, so ready is low when full even if `wb_ready`=1.
- Age rule: A is younger than F iff (wrap(A)==wrap(F) & idx(A)>idx(F)) | (wrap(A)!=wrap(F) & idx(A)<idx(F)). Equal ids are not younger.
- Flush: every entry younger than `flush_robid` is invalidated at the clock edge. Older or equal entries survive. A surviving entry 1 behind a killed head moves to head.
- Flush uses a single buffer pointer: an entry younger than the flush is never older than one behind it, so only the patterns {kill none, kill 1, kill both} occur.
- `wb_valid` = `head_valid & ~(flush_valid & younger(head))`. A killed head is never handshaked.
- Dequeue when `wb_valid & wb_ready`: entry 1 shifts to head, count decrements.
- Simultaneous dequeue and enqueue: the new entry lands behind the shifted survivor, or at head if the buffer empties. Count is unchanged.
- `wb_*` data fields reflect the head entry whenever `wb_valid`=1; they are don't-care otherwise, but are driven zero after reset.
- Reset mid-operation clears all entries immediately (asynchronous). No result from before reset is ever presented.

## Timing
- Reset values: `instr_ready`=0 while reset is asserted, 1 on the first cycle after deassert; `wb_valid`=0; `wb_result`, `wb_prd`, `wb_robid`, `wb_need_wb` = 0; count=0.
- Latency: issue handshake in cycle N → `wb_valid`=1 with its result in cycle N+1.
- Throughput: 1 instruction/cycle sustained while `wb_ready`=1 (count holds at 1).
- Backpressure: with `wb_ready`=0, two issues fill the buffer. `instr_ready` drops in the cycle after the second accept and rises in the cycle after the first dequeue.
- Head fields are stable while `wb_valid & ~wb_ready`, unless a flush kills the head.

## Test plan
- After reset, issue add src1=5, src2=7, robid=3, prd=9 → next cycle wb_valid=1, wb_result=12, wb_prd=9, wb_robid=3.
- Back-to-back issue of addw 0x7FFFFFFF+1, then sra src1=0x8000000000000000 shamt 4, with wb_ready=1 → results 0xFFFFFFFF80000000 and 0xF800000000000000 on consecutive cycles, count stays 1.
- Hold wb_ready=0, issue robids 4 and 5 → instr_ready=0 once full. Raise wb_ready → robid 4 then 5 appear in order, and instr_ready returns the cycle after the first dequeue.
- Buffer holds robids 10 and 12; flush_robid=11 → entry 12 dropped, only 10 written back. Flush_robid=9 → both dropped, wb_valid=0 in the flush cycle.
- Wrap check: buffer holds robid {wrap=1, idx=2}; flush_robid={0, 60} → the entry is younger and is dropped. With the head equal to flush_robid → it is retained.
- Assert reset while the buffer is full → wb_valid=0 and all outputs 0 immediately. After release, the first new issue appears alone with 1-cycle latency.
